// File: rtl/ram_wrq2i.sv
// Write-request queue in front of a single-write-port, async-read RAM.
// Merges two producers, drains one write per cycle, and offers pending/forward lookup.
module ram_wrq2i #(
  parameter int SZ       = 2,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int CLRONRST = 1,
  localparam int AW      = $clog2(SZ),
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stb0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] data0_i,
  output logic          rdy0_o,
  input  logic          stb1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] data1_i,
  output logic          rdy1_o,
  input  logic [AW-1:0] chkaddr_i,
  output logic          pend_o,
  output logic [DW-1:0] fwd_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [DW-1:0] wdata_o,
  output logic [CW-1:0] cnt_o,
  output logic          busy_o
);

  typedef enum logic {CLR = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ctr_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] head_q, tail_q, tail1;
  logic [AW-1:0] amem_p0 [DEPTH];
  logic [DW-1:0] dmem_p0 [DEPTH];
  logic          we_p1;
  logic [AW-1:0] waddr_p1;
  logic [DW-1:0] wdata_p1;
  logic          xfer0, xfer1, pop;
  logic [PW-1:0] idx;

  assign xfer0 = stb0_i & rdy0_o;
  assign xfer1 = stb1_i & rdy1_o;
  assign pop   = (state_q == RUN) && (cnt_q != '0);
  assign tail1 = tail_q + PW'(xfer0);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= (CLRONRST != 0) ? CLR : RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLR && ctr_q == AW'(SZ - 1)) state_d = RUN;
  end

  // Readiness comes only from registered occupancy; the pop is deliberately not credited.
  always_comb begin
    busy_o = (state_q == CLR);
    rdy0_o = (state_q == RUN) && (cnt_q <= CW'(DEPTH - 1));
    rdy1_o = (state_q == RUN) && (cnt_q <= CW'(DEPTH - 2));
  end

  // Stage p0: queue storage, written in acceptance order (port 0 first)
  always_ff @(posedge clk_i) begin
    if (xfer0) begin
      amem_p0[tail_q] <= addr0_i;
      dmem_p0[tail_q] <= data0_i;
    end
    if (xfer1) begin
      amem_p0[tail1] <= addr1_i;
      dmem_p0[tail1] <= data1_i;
    end
  end

  // Stage p1: registered RAM write port plus queue bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctr_q    <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else if (state_q == CLR) begin
      we_p1    <= 1'b1;
      waddr_p1 <= ctr_q;
      wdata_p1 <= '0;
      ctr_q    <= ctr_q + 1'b1;
    end else begin
      if (pop) begin
        we_p1    <= 1'b1;
        waddr_p1 <= amem_p0[head_q];
        wdata_p1 <= dmem_p0[head_q];
        head_q   <= head_q + 1'b1;
      end else begin
        we_p1    <= 1'b0;
      end
      tail_q <= tail_q + PW'(xfer0) + PW'(xfer1);
      cnt_q  <= cnt_q + CW'(xfer0) + CW'(xfer1) - CW'(pop);
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    pend_o = 1'b0;
    fwd_o  = '0;
    idx    = head_q;
    if (state_q == CLR) begin
      pend_o = 1'b1;
    end else begin
      if (we_p1 && waddr_p1 == chkaddr_i) begin
        pend_o = 1'b1;
        fwd_o  = wdata_p1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if (CW'(i) < cnt_q && amem_p0[idx] == chkaddr_i) begin
          pend_o = 1'b1;
          fwd_o  = dmem_p0[idx];
        end
      end
    end
  end

  assign we_o    = we_p1;
  assign waddr_o = waddr_p1;
  assign wdata_o = wdata_p1;
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_ram_wrq2i.sv
// Self-checking bench for ram_wrq2i: directed table, hand sequences and a random
// stream checked against a queue-based reference model and an ideal memory.
module tb_ram_wrq2i;

  logic        clk;
  logic        rst, stb0, stb1, rdy0, rdy1, pend, we, busy;
  logic [2:0]  addr0, addr1, chkaddr, waddr, cnt;
  logic [31:0] data0, data1, fwd, wdata;

  logic        r_rst, r_stb0, r_stb1, r_rdy0, r_rdy1, r_pend, r_we, r_busy;
  logic [2:0]  r_addr0, r_addr1, r_chk, r_waddr, r_cnt;
  logic [31:0] r_data0, r_data1, r_fwd, r_wdata;

  ram_wrq2i #(.SZ(8), .DW(32), .DEPTH(4), .CLRONRST(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .stb0_i(stb0), .addr0_i(addr0), .data0_i(data0), .rdy0_o(rdy0),
    .stb1_i(stb1), .addr1_i(addr1), .data1_i(data1), .rdy1_o(rdy1),
    .chkaddr_i(chkaddr), .pend_o(pend), .fwd_o(fwd),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .cnt_o(cnt), .busy_o(busy));

  ram_wrq2i #(.SZ(8), .DW(32), .DEPTH(4), .CLRONRST(0)) dut0 (
    .clk_i(clk), .rst_i(r_rst),
    .stb0_i(r_stb0), .addr0_i(r_addr0), .data0_i(r_data0), .rdy0_o(r_rdy0),
    .stb1_i(r_stb1), .addr1_i(r_addr1), .data1_i(r_data1), .rdy1_o(r_rdy1),
    .chkaddr_i(r_chk), .pend_o(r_pend), .fwd_o(r_fwd),
    .we_o(r_we), .waddr_o(r_waddr), .wdata_o(r_wdata), .cnt_o(r_cnt), .busy_o(r_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: pending writes in acceptance order, the write port, and
  // the memory a reader should observe if every accepted write were instant.
  typedef struct packed { logic [2:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  bit          m_run;
  int          m_ctr;
  bit          m_we;
  logic [2:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] ram_m [8];
  logic [31:0] ideal [8];

  task automatic model_reset();
    q.delete();
    m_run = 1'b0;
    m_ctr = 0;
    m_we  = 1'b0;
    m_wa  = '0;
    m_wd  = '0;
    for (int i = 0; i < 8; i++) ideal[i] = '0;
  endtask

  task automatic cyc(input bit r, input bit s0, input logic [2:0] a0, input logic [31:0] d0,
                     input bit s1, input logic [2:0] a1, input logic [31:0] d1,
                     input logic [2:0] ck);
    bit          e_r0, e_r1, x0, x1, pw, e_pend;
    logic [2:0]  pa;
    logic [31:0] pd, e_fwd, view;
    ent_t        h;
    rst = r; stb0 = s0; addr0 = a0; data0 = d0;
    stb1 = s1; addr1 = a1; data1 = d1; chkaddr = ck;
    #1;
    e_r0 = m_run && q.size() <= 3;
    e_r1 = m_run && q.size() <= 2;
    chk("rdy0", rdy0, e_r0);
    chk("rdy1", rdy1, e_r1);
    x0 = s0 && e_r0;
    x1 = s1 && e_r1;
    pw = we; pa = waddr; pd = wdata;
    @(posedge clk); #1;
    if (pw) ram_m[pa] = pd;
    if (r) begin
      model_reset();
    end else if (!m_run) begin
      m_we = 1'b1; m_wa = 3'(m_ctr); m_wd = '0;
      m_ctr++;
      if (m_ctr == 8) m_run = 1'b1;
    end else begin
      if (q.size() > 0) begin
        h = q.pop_front();
        m_we = 1'b1; m_wa = h.a; m_wd = h.d;
      end else begin
        m_we = 1'b0;
      end
      if (x0) begin q.push_back({a0, d0}); ideal[a0] = d0; end
      if (x1) begin q.push_back({a1, d1}); ideal[a1] = d1; end
    end
    chk("we", we, m_we);
    chk("waddr", waddr, m_wa);
    chk("wdata", wdata, m_wd);
    chk("cnt", cnt, q.size());
    chk("busy", busy, !m_run);
    e_pend = 1'b0; e_fwd = '0;
    if (!m_run) begin
      e_pend = 1'b1;
    end else begin
      if (m_we && m_wa == ck) begin e_pend = 1'b1; e_fwd = m_wd; end
      for (int i = 0; i < q.size(); i++)
        if (q[i].a == ck) begin e_pend = 1'b1; e_fwd = q[i].d; end
    end
    chk("pend", pend, e_pend);
    chk("fwd", fwd, e_fwd);
    view = pend ? fwd : ram_m[ck];
    chk("reader_view", view, ideal[ck]);
  endtask

  task automatic idle(input logic [2:0] ck);
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, ck);
  endtask

  typedef struct {
    bit s0; logic [2:0] a0; logic [31:0] d0;
    bit s1; logic [2:0] a1; logic [31:0] d1;
    logic [2:0] ck;
    bit e_we; logic [2:0] e_wa; logic [31:0] e_wd;
    bit e_pend; logic [31:0] e_fwd; logic [2:0] e_cnt;
  } vec_t;
  vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b1, 3'd3, 32'hA5A5A5A5, 1'b0, 3'd0, 32'h0, 3'd3, 1'b0, 3'd7, 32'h0,        1'b1, 32'hA5A5A5A5, 3'd1};
    tbl[1] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd3, 1'b1, 3'd3, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 3'd0};
    tbl[2] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd3, 1'b0, 3'd3, 32'hA5A5A5A5, 1'b0, 32'h0,        3'd0};
    tbl[3] = '{1'b1, 3'd5, 32'h11,       1'b1, 3'd5, 32'h22, 3'd5, 1'b0, 3'd3, 32'hA5A5A5A5, 1'b1, 32'h22,      3'd2};
    tbl[4] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd5, 1'b1, 3'd5, 32'h11,       1'b1, 32'h22,       3'd1};
    tbl[5] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd5, 1'b1, 3'd5, 32'h22,       1'b1, 32'h22,       3'd0};
    tbl[6] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0, 3'd5, 1'b0, 3'd5, 32'h22,       1'b0, 32'h0,        3'd0};

    rst = 1'b0; stb0 = 1'b0; stb1 = 1'b0; addr0 = '0; addr1 = '0;
    data0 = '0; data1 = '0; chkaddr = '0;
    for (int i = 0; i < 8; i++) ram_m[i] = '0;
    r_rst = 1'b1; r_stb0 = 1'b0; r_stb1 = 1'b0; r_addr0 = 3'd2; r_addr1 = '0;
    r_data0 = 32'h77; r_data1 = '0; r_chk = 3'd2;

    // No-clear instance: ready at once, first-edge request reaches the port one edge later
    @(posedge clk); #1;
    r_rst = 1'b0;
    chk("nc_rst_rdy0", r_rdy0, 1);
    chk("nc_rst_rdy1", r_rdy1, 1);
    chk("nc_rst_busy", r_busy, 0);
    chk("nc_rst_we", r_we, 0);
    chk("nc_rst_cnt", r_cnt, 0);
    chk("nc_rst_pend", r_pend, 0);
    chk("nc_rst_fwd", r_fwd, 0);
    r_stb0 = 1'b1;
    @(posedge clk); #1;
    r_stb0 = 1'b0;
    chk("nc_acc_we", r_we, 0);
    chk("nc_acc_cnt", r_cnt, 1);
    chk("nc_acc_pend", r_pend, 1);
    chk("nc_acc_fwd", r_fwd, 32'h77);
    @(posedge clk); #1;
    chk("nc_pop_we", r_we, 1);
    chk("nc_pop_waddr", r_waddr, 2);
    chk("nc_pop_wdata", r_wdata, 32'h77);
    chk("nc_pop_cnt", r_cnt, 0);
    @(posedge clk); #1;
    chk("nc_done_we", r_we, 0);
    chk("nc_done_pend", r_pend, 0);

    // Clearing instance: reset state, then SZ clear writes
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rdy0", rdy0, 0);
    chk("rst_rdy1", rdy1, 0);
    chk("rst_pend", pend, 1);
    chk("rst_fwd", fwd, 0);
    for (int i = 0; i < 8; i++) begin
      idle(3'(i));
      chk("clr_we", we, 1);
      chk("clr_waddr", waddr, i);
      chk("clr_wdata", wdata, 0);
      chk("clr_busy", busy, i < 7);
    end
    idle(3'd0);
    idle(3'd0);

    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, tbl[i].s0, tbl[i].a0, tbl[i].d0, tbl[i].s1, tbl[i].a1, tbl[i].d1, tbl[i].ck);
      chk("tbl_we", we, tbl[i].e_we);
      chk("tbl_waddr", waddr, tbl[i].e_wa);
      chk("tbl_wdata", wdata, tbl[i].e_wd);
      chk("tbl_pend", pend, tbl[i].e_pend);
      chk("tbl_fwd", fwd, tbl[i].e_fwd);
      chk("tbl_cnt", cnt, tbl[i].e_cnt);
    end
    chk("ram5_final", ram_m[5], 32'h22);

    // Both ports streaming every cycle
    for (int i = 0; i < 40; i++)
      cyc(1'b0, 1'b1, 3'($urandom), $urandom, 1'b1, 3'($urandom), $urandom, 3'($urandom));

    // Random traffic
    for (int i = 0; i < 300; i++)
      cyc(1'b0, 1'($urandom), 3'($urandom), $urandom, 1'($urandom), 3'($urandom), $urandom,
          3'($urandom));
    for (int i = 0; i < 6; i++) idle(3'd0);

    // Fill 3 entries, then reset: queued writes must vanish and clearing restarts
    cyc(1'b0, 1'b1, 3'd1, 32'hDEAD0001, 1'b1, 3'd2, 32'hDEAD0002, 3'd1);
    cyc(1'b0, 1'b1, 3'd3, 32'hDEAD0003, 1'b1, 3'd4, 32'hDEAD0004, 3'd1);
    chk("fill_cnt", cnt, 3);
    cyc(1'b1, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, 3'd3);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_we", we, 0);
    for (int i = 0; i < 8; i++) begin
      idle(3'd3);
      chk("reclr_waddr", waddr, i);
      chk("reclr_wdata", wdata, 0);
    end
    for (int i = 0; i < 100; i++)
      cyc(1'b0, 1'($urandom), 3'($urandom), $urandom, 1'($urandom), 3'($urandom), $urandom,
          3'($urandom));
    for (int i = 0; i < 6; i++) idle(3'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ram_wrq2i.md
# ram_wrq2i

Write-request queue placed directly upstream of the single write port of the team's multi-read-port RAM (register-file style, asynchronous reads). It accepts write requests from two producers over valid/ready handshakes and buffers them in a DEPTH-entry FIFO. It drains one write per cycle onto a registered write port (we/addr/data). It also gives readers a pending/forward lookup so they never consume a stale RAM word, and can zero the whole RAM after reset.

## Interface
- SZ, 2: RAM word count; AW = clog2(SZ).
- DW, 32: data width.
- DEPTH, 4: queue entries; power of two, >= 2.
- CLRONRST, 1: 1 = write zero to every RAM address after reset; 0 = start directly in RUN.

- clk_i  in  1  clock; all logic on posedge clk_i.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- stb0_i  in  1  port 0 request valid.
- addr0_i  in  AW  port 0 write address.
- data0_i  in  DW  port 0 write data.
- rdy0_o  out  1  port 0 ready.
- stb1_i  in  1  port 1 request valid.
- addr1_i  in  AW  port 1 write address.
- data1_i  in  DW  port 1 write data.
- rdy1_o  out  1  port 1 ready.
- chkaddr_i  in  AW  lookup address from the reader side.
- pend_o  out  1  a write to chkaddr_i is queued or in flight.
- fwd_o  out  DW  data of the youngest pending write to chkaddr_i; 0 when pend_o=0.
- we_o  out  1  RAM write enable (registered).
- waddr_o  out  AW  RAM write address (registered).
- wdata_o  out  DW  RAM write data (registered).
- cnt_o  out  clog2(DEPTH)+1  queue occupancy (registered).
- busy_o  out  1  high while state = CLR.

## Operation
- States: CLR, RUN. rst_i forces state to CLR if CLRONRST=1, else to RUN. Reset also clears the queue (cnt=0, head=tail=0), sets the clear counter to 0 and clears we_o/waddr_o/wdata_o.
- CLR: on each edge, we_o<=1, waddr_o<=ctr, wdata_o<=0, ctr<=ctr+1. On the edge that issues ctr==SZ-1, state<=RUN. rdy0_o=rdy1_o=0. pend_o=1 and fwd_o=0 for every chkaddr_i.
- RUN readiness depends only on registered cnt, with no combinational path from stb to rdy:
  - rdy0_o = (cnt <= DEPTH-1)
  - rdy1_o = (cnt <= DEPTH-2)
- Transfer on a port = stb & rdy at the edge. If both ports transfer in the same edge, port 0 is enqueued first (older) and port 1 second.
- Drain: at any RUN edge with cnt>0, pop the head entry into we_o/waddr_o/wdata_o with we_o<=1; otherwise we_o<=0. waddr_o/wdata_o hold their value when we_o<=0.
- cnt_next = cnt + xfer0 + xfer1 - pop. The dequeue is not counted in rdy, so overflow and underflow are impossible.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Lookup is combinational over the valid queue entries plus the output register when we_o=1.
  - Priority, youngest first: tail-1, ..., head, then output register.
  - pend_o = any match; fwd_o = data of the highest-priority match.

## Timing
- Request accepted at edge E0 → entry sits at the queue head (if the queue was empty) → popped at E1 → we_o=1 during E1..E2 → RAM word updated at E2.
- Minimum acceptance-to-RAM-update latency: 2 edges.
- Sustained throughput: one write per cycle.
- pend_o covers the entry from E0 through E2. At E2 the RAM holds the new value, so there is no visibility gap for an asynchronous-read RAM.
- CLR: we_o high for exactly SZ consecutive cycles, starting the cycle after the last reset edge. rdy is first high in the cycle after the final CLR write is issued.
- Reset asserted mid-operation drops all queued and in-flight writes: we_o=0 in the cycle after the reset edge.
- Reset values of outputs:
  - rdy0_o=rdy1_o=0 if CLRONRST=1, else 1.
  - pend_o: 1 if CLRONRST=1, else 0.
  - fwd_o=0, we_o=0, waddr_o=0, wdata_o=0, cnt_o=0.
  - busy_o=CLRONRST.

## Test plan
- SZ=8, CLRONRST=1, release reset → we_o=1 for 8 cycles with waddr_o 0..7 and wdata_o=0; busy_o then drops; rdy0_o=rdy1_o=1.
- Single port-0 write addr=3, data=0xA5A5A5A5 at E0 → we_o=1, waddr_o=3, wdata_o=0xA5A5A5A5 during E1..E2; with chkaddr_i=3, pend_o=1 from E0 to E2 and fwd_o=0xA5A5A5A5; pend_o=0 after E2.
- Both ports in the same edge to addr=5 (port 0 data 0x11, port 1 data 0x22) → two consecutive we_o cycles, 0x11 then 0x22; fwd_o=0x22 throughout; final RAM word 0x22.
- DEPTH=4, both ports streaming every cycle → rdy1_o low at cnt>=3 and rdy0_o low at cnt=4; cnt_o never exceeds 4; no request lost or duplicated; issue order equals acceptance order with port 0 ahead of port 1.
- Fill 3 entries, assert rst_i for one edge → cnt_o=0 and we_o=0 the next cycle; the CLR sequence restarts at addr 0; none of the dropped writes appear on we_o.
- CLRONRST=0: no CLR writes; rdy high immediately after reset; a request accepted on the first edge after reset reaches we_o one edge later.
